bk_sector_ctrl: RTL and testbench
=================================

Name: bk_sector_ctrl

Overview:
- Backup-save streaming engine between the hps_io SD sector interface (sd_* signals, 256 x 16-bit words per 512-byte sector) and the 32-bit DWORD backup-memory bus (the SDRAM channel carrying SRAM/Flash/EEPROM save data).
- On load it collects one sector into a local 128 x 32 buffer, then writes it to memory.
- On save it first fills the buffer from memory, then hands the sector to the HPS.
- Drives LED/reset-hold status (busy) for the top level.

Parameters:
- SECT_DW, 128, DWORDs per sector (fixed 512 bytes; do not change).
- LBA_W, 9, width of sector counter and sectors input.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load_req  in  1  level; its rising edge starts a load.
- save_req  in  1  level; its rising edge starts a save.
- sectors  in  LBA_W  number of sectors to transfer; 0 = disabled.
- base_addr  in  24  DWORD base address [25:2] of the save area.
- busy  out  1  high from accepted request until done.
- done  out  1  one-cycle pulse when the last sector completes.
- sd_lba  out  32  current sector number.
- sd_rd  out  1  sector read request to HPS.
- sd_wr  out  1  sector write request to HPS.
- sd_ack  in  1  HPS acknowledge, high for the duration of the sector transfer.
- sd_buff_addr  in  8  16-bit word index within the sector.
- sd_buff_dout  in  16  load data from HPS.
- sd_buff_din  out  16  save data to HPS.
- sd_buff_wr  in  1  load data strobe.
- mem_addr  out  24  DWORD address [25:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_rnw  out  1  1 = read, 0 = write.
- mem_req  out  1  one-cycle request pulse.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset (async, reset_n=0):
  - State machine goes to IDLE.
  - All of these outputs = 0: busy, done, sd_rd, sd_wr, sd_lba, mem_req, mem_rnw, mem_addr, mem_wdata, sd_buff_din.
  - Edge detectors clear; a request level held through reset is not seen as an edge.
  - Reset mid-transfer abandons the transfer; no done pulse.
- State machine states: IDLE, FILL, SD_REQ, SD_XFER, FLUSH, NEXT.
- IDLE:
  - An edge on load_req or save_req with sectors != 0 is accepted: sets busy, sd_lba=0, latches direction.
  - Load goes to SD_REQ; save goes to FILL.
  - Simultaneous edges: load wins; the save edge is dropped.
  - Edges while busy, or while sectors==0, are ignored (no busy, no done).
- FILL (save only):
  - 128 sequential memory reads, idx 0..127, to mem_addr = base_addr + sd_lba*128 + idx (24-bit wrap).
  - Exactly one outstanding request: mem_req is pulsed, then the block waits for mem_ack, stores mem_rdata in buf[idx], and issues the next request on the following cycle at the earliest.
  - After idx 127 is acked, goes to SD_REQ.
- SD_REQ:
  - Asserts sd_rd (load) or sd_wr (save) and holds it until the sd_ack rising edge.
  - Clears both in the cycle after that edge, then goes to SD_XFER.
- SD_XFER:
  - Load: on each sd_buff_wr, word addr a goes to buf[a[7:1]]; even a fills bits [15:0], odd a fills [31:16].
  - Save: sd_buff_din is registered, one cycle after sd_buff_addr: buf[addr[7:1]] half-selected by the registered addr[0].
  - sd_buff_wr outside SD_XFER is ignored.
  - On the sd_ack falling edge: load goes to FLUSH, save goes to NEXT.
- FLUSH (load only): 128 writes of buf[idx] to the same address formula, same one-outstanding rule, then goes to NEXT.
- NEXT:
  - If sd_lba == sectors-1: done pulses for 1 cycle, busy falls in the same cycle, state returns to IDLE.
  - Otherwise: sd_lba+1, then FILL (save) or SD_REQ (load).
- sectors and base_addr are sampled only at acceptance; later changes have no effect until the next request.

Test Plan:
- Load 1 sector: sectors=1, base=0x000100, HPS writes words k=0..255 with value k. Required: 128 writes; addr 0x000100 gets 0x00010000, addr 0x00017F gets 0x00FF00FE; then done=1 for 1 cycle and busy=0.
- Save 2 sectors, memory returns data = address: 256 reads. On sd_lba=1, sd_buff_addr=3 gives sd_buff_din=0x0000 one cycle later, addr 2 gives 0x0081. sd_wr is asserted twice and cleared after each sd_ack rise.
- Simultaneous load_req/save_req edges: only sd_rd is asserted, never sd_wr. A second save edge while busy causes no extra done.
- Memory ack latency of 7 cycles: mem_req is never re-asserted before mem_ack; exactly 128 req pulses per sector.
- sectors=0 with a load edge: busy stays 0, no sd_rd, no done.
- reset_n low during FLUSH at idx 40: all outputs are 0 immediately (asynchronously). After release, no done and no further mem_req until a new edge.

Source files
------------

// File: rtl/bk_sector_ctrl.sv
// Backup-save sector engine: moves 512-byte sectors between the HPS SD buffer
// interface (16-bit words) and the 32-bit backup memory bus via a local buffer.
module bk_sector_ctrl #(
  parameter int SECT_DW = 128,
  parameter int LBA_W   = 9
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             load_req,
  input  logic             save_req,
  input  logic [LBA_W-1:0] sectors,
  input  logic [23:0]      base_addr,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  input  logic [7:0]       sd_buff_addr,
  input  logic [15:0]      sd_buff_dout,
  output logic [15:0]      sd_buff_din,
  input  logic             sd_buff_wr,
  output logic [23:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             mem_rnw,
  output logic             mem_req,
  input  logic             mem_ack
);

  localparam int IDX_W = $clog2(SECT_DW);

  typedef enum logic [2:0] {IDLE, FILL, SD_REQ, SD_XFER, FLUSH, NEXT} state_e;

  state_e             state_q;
  logic               busy_q, done_q, sd_rd_q, sd_wr_q;
  logic               mem_req_q, mem_rnw_q;
  logic [31:0]        sd_lba_q, mem_wdata_q;
  logic [23:0]        mem_addr_q, base_q;
  logic [15:0]        sd_buff_din_q;
  logic [LBA_W-1:0]   sectors_q;
  logic [IDX_W-1:0]   idx_q;
  logic               pend_q, load_q;
  logic               load_prev_q, save_prev_q, ack_prev_q, armed_q;
  logic [31:0]        sect_buf [SECT_DW];

  logic               load_edge, save_edge, ack_rise, ack_fall;
  logic               last_idx, last_sect;
  logic [23:0]        mem_addr_d;

  // armed_q suppresses a request level that was already high when reset released
  assign load_edge  = armed_q & load_req & ~load_prev_q;
  assign save_edge  = armed_q & save_req & ~save_prev_q;
  assign ack_rise   = sd_ack & ~ack_prev_q;
  assign ack_fall   = ~sd_ack & ack_prev_q;
  assign last_idx   = (idx_q == IDX_W'(SECT_DW - 1));
  assign last_sect  = (sd_lba_q[LBA_W-1:0] == (sectors_q - LBA_W'(1)));
  assign mem_addr_d = base_q + (24'(sd_lba_q[LBA_W-1:0]) << IDX_W) + 24'(idx_q);

  always_ff @(posedge clk_sys) begin
    if (state_q == FILL && pend_q && mem_ack) begin
      sect_buf[idx_q] <= mem_rdata;
    end else if (state_q == SD_XFER && load_q && sd_buff_wr) begin
      if (sd_buff_addr[0]) sect_buf[sd_buff_addr[7:1]][31:16] <= sd_buff_dout;
      else                 sect_buf[sd_buff_addr[7:1]][15:0]  <= sd_buff_dout;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sd_rd_q       <= 1'b0;
      sd_wr_q       <= 1'b0;
      sd_lba_q      <= '0;
      mem_req_q     <= 1'b0;
      mem_rnw_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      sd_buff_din_q <= '0;
      sectors_q     <= '0;
      base_q        <= '0;
      idx_q         <= '0;
      pend_q        <= 1'b0;
      load_q        <= 1'b0;
      load_prev_q   <= 1'b0;
      save_prev_q   <= 1'b0;
      ack_prev_q    <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      load_prev_q <= load_req;
      save_prev_q <= save_req;
      ack_prev_q  <= sd_ack;
      armed_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((load_edge || save_edge) && sectors != '0) begin
            busy_q    <= 1'b1;
            sd_lba_q  <= '0;
            load_q    <= load_edge;
            sectors_q <= sectors;
            base_q    <= base_addr;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            if (load_edge) begin
              sd_rd_q <= 1'b1;
              state_q <= SD_REQ;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FILL: begin
          if (!pend_q) begin
            mem_req_q  <= 1'b1;
            mem_rnw_q  <= 1'b1;
            mem_addr_q <= mem_addr_d;
            pend_q     <= 1'b1;
          end else if (mem_ack) begin
            pend_q <= 1'b0;
            if (last_idx) begin
              idx_q   <= '0;
              sd_wr_q <= 1'b1;
              state_q <= SD_REQ;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        SD_REQ: begin
          if (ack_rise) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= SD_XFER;
          end
        end
        SD_XFER: begin
          if (!load_q) begin
            sd_buff_din_q <= sd_buff_addr[0] ? sect_buf[sd_buff_addr[7:1]][31:16]
                                             : sect_buf[sd_buff_addr[7:1]][15:0];
          end
          if (ack_fall) state_q <= load_q ? FLUSH : NEXT;
        end
        FLUSH: begin
          if (!pend_q) begin
            mem_req_q   <= 1'b1;
            mem_rnw_q   <= 1'b0;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= sect_buf[idx_q];
            pend_q      <= 1'b1;
          end else if (mem_ack) begin
            pend_q <= 1'b0;
            if (last_idx) begin
              idx_q   <= '0;
              state_q <= NEXT;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        NEXT: begin
          if (last_sect) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            sd_lba_q <= sd_lba_q + 32'd1;
            idx_q    <= '0;
            if (load_q) begin
              sd_rd_q <= 1'b1;
              state_q <= SD_REQ;
            end else begin
              state_q <= FILL;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sd_lba      = sd_lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_buff_din = sd_buff_din_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_rnw     = mem_rnw_q;
  assign mem_req     = mem_req_q;

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// Scoreboard bench for bk_sector_ctrl: HPS and memory models drive the DUT,
// expected memory operations and save words are queued and checked by monitors.
module tb_bk_sector_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_req = 1'b0, save_req = 1'b0;
  logic [8:0]  sectors = '0;
  logic [23:0] base_addr = '0;
  logic        busy, done, sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_buff_addr = '0;
  logic [15:0] sd_buff_dout = '0;
  logic [15:0] sd_buff_din;
  logic        sd_buff_wr = 1'b0;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_rnw, mem_req;
  logic        mem_ack = 1'b0;

  bk_sector_ctrl #(.SECT_DW(128), .LBA_W(9)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .load_req(load_req), .save_req(save_req),
    .sectors(sectors), .base_addr(base_addr), .busy(busy), .done(done),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rnw(mem_rnw), .mem_req(mem_req), .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [23:0] addr;
    logic        rnw;
    logic [31:0] data;
  } memOp_t;

  memOp_t      expQ[$];
  memOp_t      monOp;
  logic [15:0] dinQ[$];
  logic [15:0] loadWords [4][256];

  int compared = 0, mismatched = 0;
  int doneCount = 0, reqCount = 0, writeReqCount = 0, sdRdCount = 0, sdWrCount = 0;
  int memLatency = 1, respLat = 1, hpsDelay = 0, curSector = 0;
  bit randLatency = 1'b0, addrAsData = 1'b0, expectLoad = 1'b0, dinActive = 1'b0;
  logic        memBusy = 1'b0, lastDone = 1'b0, hpsLoad = 1'b0;
  logic [23:0] curBase = '0, respAddr = '0;
  logic [31:0] dataSeed = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference memory image: either data equals address, or a seeded hash of it
  function automatic logic [31:0] memData(input logic [23:0] a);
    return addrAsData ? {8'h00, a} : (({8'h00, a} * 32'h9E3779B1) ^ dataSeed);
  endfunction

  function automatic logic [23:0] sectAddr(input int s, input int i);
    return curBase + 24'(s * 128 + i);
  endfunction

  function automatic logic [15:0] expectDin(input int s, input int k);
    logic [31:0] w;
    w = memData(sectAddr(s, k / 2));
    return (k % 2 == 1) ? w[31:16] : w[15:0];
  endfunction

  // Memory responder: one ack per request after the configured latency
  initial forever begin
    @(negedge clk_sys);
    if (mem_req === 1'b1) begin
      respAddr = mem_addr;
      respLat  = randLatency ? int'($urandom_range(1, 7)) : memLatency;
      repeat (respLat) @(negedge clk_sys);
      mem_rdata = memData(respAddr);
      mem_ack   = 1'b1;
      memBusy   = 1'b0;
      @(negedge clk_sys);
      mem_ack = 1'b0;
    end
  end

  // Memory / done monitor
  initial forever begin
    @(negedge clk_sys);
    if (mem_req === 1'b1) begin
      reqCount++;
      if (mem_rnw === 1'b0) writeReqCount++;
      checkOutput("memOneOutstanding", 32'(memBusy), 32'd0);
      memBusy = 1'b1;
      if (expQ.size() == 0) begin
        checkOutput("memUnexpectedReq", 32'd1, 32'd0);
      end else begin
        monOp = expQ.pop_front();
        checkOutput("memAddr", 32'(mem_addr), 32'(monOp.addr));
        checkOutput("memRnw", 32'(mem_rnw), 32'(monOp.rnw));
        if (!monOp.rnw) checkOutput("memWdata", mem_wdata, monOp.data);
      end
    end
    if (done === 1'b1) begin
      doneCount++;
      checkOutput("busyAtDone", 32'(busy), 32'd0);
      checkOutput("donePulseWidth", 32'(lastDone), 32'd0);
    end
    lastDone = done;
  end

  // Save-data monitor: one cycle after each presented address
  initial forever begin
    @(posedge clk_sys);
    #1;
    if (dinActive) begin
      if (dinQ.size() == 0) checkOutput("dinUnderflow", 32'd1, 32'd0);
      else checkOutput("sdBuffDin", 32'(sd_buff_din), 32'(dinQ.pop_front()));
    end
  end

  // HPS model: acknowledges sector requests and streams 256 words
  initial forever begin
    @(negedge clk_sys);
    if (sd_rd === 1'b1 || sd_wr === 1'b1) begin
      hpsLoad = sd_rd;
      checkOutput("sdDirection", 32'(sd_rd), 32'(expectLoad));
      checkOutput("sdLba", sd_lba, 32'(curSector));
      if (hpsLoad) sdRdCount++;
      else sdWrCount++;
      hpsDelay = $urandom_range(0, 3);
      repeat (hpsDelay) @(negedge clk_sys);
      checkOutput("sdReqHeld", 32'(sd_rd | sd_wr), 32'd1);
      sd_ack = 1'b1;
      @(negedge clk_sys);
      checkOutput("sdReqCleared", 32'({sd_rd, sd_wr}), 32'd0);
      for (int k = 0; k < 256; k++) begin
        sd_buff_addr = 8'(k);
        if (hpsLoad) begin
          sd_buff_dout = loadWords[curSector & 3][k];
          sd_buff_wr   = 1'b1;
        end else begin
          dinActive = 1'b1;
          dinQ.push_back(expectDin(curSector, k));
        end
        @(negedge clk_sys);
      end
      sd_buff_wr = 1'b0;
      dinActive  = 1'b0;
      sd_ack     = 1'b0;
      curSector++;
    end
  end

  task automatic applyStimulus(input bit doLoad, input bit doSave, input int n,
                               input logic [23:0] base, input int lat, input bit rndLat,
                               input bit ramp);
    curBase     = base;
    curSector   = 0;
    expectLoad  = doLoad;
    memLatency  = lat;
    randLatency = rndLat;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < 256; k++) loadWords[s & 3][k] = ramp ? 16'(k) : 16'($urandom);
      for (int i = 0; i < 128; i++) begin
        if (doLoad) expQ.push_back('{sectAddr(s, i), 1'b0, {loadWords[s & 3][2*i+1], loadWords[s & 3][2*i]}});
        else if (doSave) expQ.push_back('{sectAddr(s, i), 1'b1, 32'd0});
      end
    end
    sectors   = 9'(n);
    base_addr = base;
    @(negedge clk_sys);
    load_req = doLoad;
    save_req = doSave;
    repeat (3) @(negedge clk_sys);
    load_req  = 1'b0;
    save_req  = 1'b0;
    sectors   = 9'($urandom);
    base_addr = 24'($urandom);
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (doneCount < target && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    if (doneCount < target) checkOutput("doneTimeout", 32'(doneCount), 32'(target));
  endtask

  task automatic runOp(input bit doLoad, input bit doSave, input int n, input logic [23:0] base,
                       input int lat, input bit rndLat, input bit ramp, input bit extraSave);
    int startDone = doneCount;
    int startReq  = reqCount;
    int startRd   = sdRdCount;
    int startWr   = sdWrCount;
    int target    = doneCount + ((n > 0) ? 1 : 0);
    applyStimulus(doLoad, doSave, n, base, lat, rndLat, ramp);
    if (extraSave) begin
      repeat (10) @(negedge clk_sys);
      save_req = 1'b1;
      repeat (3) @(negedge clk_sys);
      save_req = 1'b0;
    end
    waitDone(target, n * 5000 + 100);
    repeat ((n == 0) ? 30 : 10) @(negedge clk_sys);
    checkOutput("doneCount", 32'(doneCount - startDone), 32'(target - startDone));
    checkOutput("busyIdle", 32'(busy), 32'd0);
    checkOutput("expQEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("dinQEmpty", 32'(dinQ.size()), 32'd0);
    checkOutput("memReqCount", 32'(reqCount - startReq), 32'(128 * n));
    checkOutput("sdRdCount", 32'(sdRdCount - startRd), doLoad ? 32'(n) : 32'd0);
    checkOutput("sdWrCount", 32'(sdWrCount - startWr), (!doLoad && doSave) ? 32'(n) : 32'd0);
  endtask

  int rstDone, rstReq, rstWrites;
  bit rndDir;

  initial begin
    repeat (3) @(negedge clk_sys);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstSdRdWr", 32'({sd_rd, sd_wr}), 32'd0);
    checkOutput("rstSdLba", sd_lba, 32'd0);
    checkOutput("rstMemReq", 32'({mem_req, mem_rnw}), 32'd0);
    checkOutput("rstMemAddr", 32'(mem_addr), 32'd0);
    checkOutput("rstMemWdata", mem_wdata, 32'd0);
    checkOutput("rstSdBuffDin", 32'(sd_buff_din), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    runOp(1'b1, 1'b0, 1, 24'h000100, 2, 1'b0, 1'b1, 1'b0);
    addrAsData = 1'b1;
    runOp(1'b0, 1'b1, 2, 24'h000000, 2, 1'b0, 1'b0, 1'b0);
    addrAsData = 1'b0;
    dataSeed   = $urandom;
    runOp(1'b1, 1'b1, 1, 24'($urandom), 1, 1'b1, 1'b0, 1'b1);
    runOp(1'b1, 1'b0, 2, 24'($urandom), 7, 1'b0, 1'b0, 1'b0);
    runOp(1'b1, 1'b0, 0, 24'h000200, 1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      rndDir   = 1'($urandom_range(0, 1));
      dataSeed = $urandom;
      runOp(rndDir, !rndDir, int'($urandom_range(1, 2)),
            (r == 0) ? 24'hFFFFC0 : 24'($urandom), 1, 1'b1, 1'b0, 1'b0);
    end

    // Reset in the middle of a flush, with load_req held high across reset
    rstWrites = writeReqCount + 41;
    applyStimulus(1'b1, 1'b0, 1, 24'($urandom), 1, 1'b0, 1'b0);
    load_req = 1'b1;
    for (int n = 0; n < 3000 && writeReqCount < rstWrites; n++) @(negedge clk_sys);
    checkOutput("reachedFlushIdx40", 32'(writeReqCount >= rstWrites), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("asyncRstBusy", 32'(busy), 32'd0);
    checkOutput("asyncRstFlags", 32'({done, sd_rd, sd_wr, mem_req, mem_rnw}), 32'd0);
    checkOutput("asyncRstSdLba", sd_lba, 32'd0);
    checkOutput("asyncRstMemAddr", 32'(mem_addr), 32'd0);
    checkOutput("asyncRstMemWdata", mem_wdata, 32'd0);
    checkOutput("asyncRstSdBuffDin", 32'(sd_buff_din), 32'd0);
    expQ.delete();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    memBusy = 1'b0;
    rstDone = doneCount;
    rstReq  = reqCount;
    repeat (40) @(negedge clk_sys);
    checkOutput("postRstNoDone", 32'(doneCount), 32'(rstDone));
    checkOutput("postRstNoReq", 32'(reqCount), 32'(rstReq));
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    load_req = 1'b0;
    repeat (2) @(negedge clk_sys);

    dataSeed = $urandom;
    runOp(1'b0, 1'b1, 1, 24'($urandom), 1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
